// File: rtl/stage_pkg.sv
// Stage encoding, scheduler FSM states and default enemy slot counts shared by
// the stage controller and the enemy spawn scheduler.
package stage_pkg;

   localparam logic [1:0] STAGE_INIT   = 2'b00;
   localparam logic [1:0] STAGE_NORMAL = 2'b01;
   localparam logic [1:0] STAGE_BOSS   = 2'b10;
   localparam logic [1:0] STAGE_CLEAR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      SPAWN = 2'b10,
      DONE  = 2'b11
   } sched_state_t;

   localparam int unsigned DEFAULT_FLY_COUNT      = 4;
   localparam int unsigned DEFAULT_MOSQUITO_COUNT = 12;

endpackage

// File: rtl/spawn_interval_timer.sv
// Interval timer: after a start pulse, raises a one-cycle expire pulse in the
// INTERVAL-th cycle (count == INTERVAL-1), then idles until restarted.
module spawn_interval_timer #(
   parameter int unsigned INTERVAL = 12_500_000,
   parameter int unsigned W        = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expire
);

   logic [W-1:0] count;
   logic         running;

   // expire is registered one cycle early so it lines up with count == INTERVAL-1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         running <= 1'b0;
         expire  <= 1'b0;
      end else if (clear) begin
         count   <= '0;
         running <= 1'b0;
         expire  <= 1'b0;
      end else if (start) begin
         count   <= '0;
         running <= 1'b1;
         expire  <= 1'b0;
      end else if (running) begin
         count  <= count + W'(1);
         expire <= (count == W'(INTERVAL - 2));
         if (count == W'(INTERVAL - 1)) begin
            running <= 1'b0;
         end
      end else begin
         expire <= 1'b0;
      end
   end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: staggered fly/mosquito spawn pulses on NORMAL entry,
// same-cycle spider pulse on BOSS entry. Optional macro SPAWN_SKIP_ALIVE_EN.
module enemy_spawn_scheduler
   import stage_pkg::*;
#(
   parameter int unsigned FLY_COUNT      = DEFAULT_FLY_COUNT,
   parameter int unsigned MOSQUITO_COUNT = DEFAULT_MOSQUITO_COUNT,
   parameter int unsigned SPAWN_INTERVAL = 12_500_000,
   parameter int unsigned INTERVAL_W     = 24
) (
   input  logic                      clk25,
   input  logic                      rst,
   input  logic [1:0]                stage_state,
   input  logic [FLY_COUNT-1:0]      fly_alive,
   input  logic [MOSQUITO_COUNT-1:0] mosquito_alive,
   input  logic                      spider_alive,
   output logic [FLY_COUNT-1:0]      fly_spawn,
   output logic [MOSQUITO_COUNT-1:0] mosquito_spawn,
   output logic                      spider_spawn,
   output logic                      spawn_done,
   output logic [7:0]                wave_count
);

   localparam int unsigned SLOTS = FLY_COUNT + MOSQUITO_COUNT;
   localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(SLOTS - 1);

   sched_state_t              state, state_d;
   logic [IDX_W-1:0]          index, index_d, load_idx;
   logic [1:0]                prev_stage;
   logic                      armed;
   logic                      in_normal, enter_normal, enter_boss;
   logic                      timer_start, timer_clear, timer_expire;
   logic                      load_req, load_en, done_d;
   logic [7:0]                wave_d;
   logic [FLY_COUNT-1:0]      fly_d;
   logic [MOSQUITO_COUNT-1:0] mosquito_d;

   // After reset, NORMAL only counts as entered once a non-NORMAL stage has been seen
   assign in_normal    = (stage_state == STAGE_NORMAL);
   assign enter_normal = in_normal && (prev_stage != STAGE_NORMAL) && armed;
   assign enter_boss   = (stage_state == STAGE_BOSS) && (prev_stage != STAGE_BOSS);
   assign spider_spawn = enter_boss && !rst;

   spawn_interval_timer #(
      .INTERVAL (SPAWN_INTERVAL),
      .W        (INTERVAL_W)
   ) u_timer (
      .clk    (clk25),
      .rst    (rst),
      .start  (timer_start),
      .clear  (timer_clear),
      .expire (timer_expire)
   );

`ifdef SPAWN_SKIP_ALIVE_EN
   logic [SLOTS-1:0] slot_alive;
   logic             skip_q, skip_d;
   logic             unused_alive;

   assign slot_alive   = {mosquito_alive, fly_alive};
   assign unused_alive = spider_alive;

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) skip_q <= 1'b0;
      else     skip_q <= skip_d;
   end
`else
   logic unused_alive;
   assign unused_alive = ^{spider_alive, fly_alive, mosquito_alive};
`endif

   // Next-state logic; load_req marks the transition into SPAWN for slot load_idx
   always_comb begin
      state_d     = state;
      index_d     = index;
      done_d      = 1'b0;
      wave_d      = wave_count;
      timer_start = 1'b0;
      timer_clear = 1'b0;
      load_req    = 1'b0;
      load_idx    = index;
      case (state)
         IDLE: begin
            if (enter_normal) begin
               state_d     = WAIT;
               index_d     = '0;
               timer_start = 1'b1;
               if (wave_count != 8'hFF) wave_d = wave_count + 8'd1;
            end
         end
         WAIT: begin
            if (!in_normal) begin
               state_d     = IDLE;
               timer_clear = 1'b1;
            end else if (timer_expire) begin
               state_d  = SPAWN;
               load_req = 1'b1;
            end
         end
         SPAWN: begin
            if (!in_normal) begin
               state_d     = IDLE;
               timer_clear = 1'b1;
            end else if (index == LAST_SLOT) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               index_d = index + IDX_W'(1);
`ifdef SPAWN_SKIP_ALIVE_EN
               if (skip_q) begin
                  state_d  = SPAWN;
                  load_req = 1'b1;
                  load_idx = index + IDX_W'(1);
               end else
`endif
               begin
                  state_d     = WAIT;
                  timer_start = 1'b1;
               end
            end
         end
         DONE: begin
            if (in_normal) done_d  = 1'b1;
            else           state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Decode the loaded slot into a one-hot fly or mosquito pulse
   always_comb begin
      load_en = load_req;
`ifdef SPAWN_SKIP_ALIVE_EN
      load_en = load_req && !slot_alive[load_idx];
      skip_d  = load_req && slot_alive[load_idx];
`endif
      fly_d      = '0;
      mosquito_d = '0;
      for (int i = 0; i < FLY_COUNT; i++) begin
         fly_d[i] = load_en && (load_idx == IDX_W'(i));
      end
      for (int i = 0; i < MOSQUITO_COUNT; i++) begin
         mosquito_d[i] = load_en && (load_idx == IDX_W'(FLY_COUNT + i));
      end
   end

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         index          <= '0;
         prev_stage     <= STAGE_INIT;
         armed          <= 1'b0;
         fly_spawn      <= '0;
         mosquito_spawn <= '0;
         spawn_done     <= 1'b0;
         wave_count     <= '0;
      end else begin
         state          <= state_d;
         index          <= index_d;
         prev_stage     <= stage_state;
         armed          <= armed || !in_normal;
         fly_spawn      <= fly_d;
         mosquito_spawn <= mosquito_d;
         spawn_done     <= done_d;
         wave_count     <= wave_d;
      end
   end

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Self-checking bench for enemy_spawn_scheduler (FLY=2, MOSQUITO=3, INTERVAL=4)
// against a cycle-schedule reference model of the spawn timeline.
module tb_enemy_spawn_scheduler;

   localparam int unsigned FC     = 2;
   localparam int unsigned MC     = 3;
   localparam int unsigned IV     = 4;
   localparam int unsigned IW     = 24;
   localparam int          N      = FC + MC;
   localparam int          PERIOD = IV + 1;

   logic          clk25 = 1'b0;
   logic          rst;
   logic [1:0]    stage_state;
   logic [FC-1:0] fly_alive;
   logic [MC-1:0] mosquito_alive;
   logic          spider_alive;
   logic [FC-1:0] fly_spawn;
   logic [MC-1:0] mosquito_spawn;
   logic          spider_spawn;
   logic          spawn_done;
   logic [7:0]    wave_count;

   int errors = 0;
   int checks = 0;

   // Reference model: time since the last counted NORMAL entry decides everything
   int         cyc;
   logic [1:0] m_prev;
   bit         m_armed;
   bit         m_run;
   int         m_entry;
   int         m_wave;

   enemy_spawn_scheduler #(
      .FLY_COUNT      (FC),
      .MOSQUITO_COUNT (MC),
      .SPAWN_INTERVAL (IV),
      .INTERVAL_W     (IW)
   ) dut (
      .clk25          (clk25),
      .rst            (rst),
      .stage_state    (stage_state),
      .fly_alive      (fly_alive),
      .mosquito_alive (mosquito_alive),
      .spider_alive   (spider_alive),
      .fly_spawn      (fly_spawn),
      .mosquito_spawn (mosquito_spawn),
      .spider_spawn   (spider_spawn),
      .spawn_done     (spawn_done),
      .wave_count     (wave_count)
   );

   always #20 clk25 = ~clk25;

   task automatic check_bits(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_prev  = 2'b00;
      m_armed = 1'b0;
      m_run   = 1'b0;
      m_entry = 0;
      m_wave  = 0;
   endtask

   task automatic check_cycle(input logic [1:0] st);
      logic [FC-1:0] ef;
      logic [MC-1:0] em;
      logic          ed;
      logic          es;
      int            e;
      int            k;
      ef = '0;
      em = '0;
      ed = 1'b0;
      if (m_run) begin
         e = cyc - m_entry;
         if (e % PERIOD == 0) begin
            k = e / PERIOD;
            if (k >= 1 && k <= N) begin
               if (k - 1 < FC) ef[k-1] = 1'b1;
               else            em[k-1-FC] = 1'b1;
            end
         end
         ed = (e >= N * PERIOD + 1);
      end
      es = (st == 2'b10) && (m_prev != 2'b10);
      check_bits("fly_spawn", 32'(fly_spawn), 32'(ef));
      check_bits("mosquito_spawn", 32'(mosquito_spawn), 32'(em));
      check_bits("spider_spawn", 32'(spider_spawn), 32'(es));
      check_bits("spawn_done", 32'(spawn_done), 32'(ed));
      check_bits("wave_count", 32'(wave_count), 32'(m_wave));
      check_bits("onehot", 32'($countones({fly_spawn, mosquito_spawn}) <= 1), 32'd1);
   endtask

   task automatic model_update(input logic [1:0] st);
      if (st == 2'b01 && m_prev != 2'b01 && m_armed) begin
         m_entry = cyc;
         m_run   = 1'b1;
         if (m_wave < 255) m_wave++;
      end else if (st != 2'b01) begin
         m_run = 1'b0;
      end
      if (st != 2'b01) m_armed = 1'b1;
      m_prev = st;
      cyc++;
   endtask

   // Called just after a falling edge; returns at the next falling edge
   task automatic tick(input logic [1:0] st);
      stage_state    = st;
      fly_alive      = FC'($urandom);
      mosquito_alive = MC'($urandom);
      spider_alive   = 1'($urandom);
      #1;
      check_cycle(st);
      model_update(st);
      @(negedge clk25);
   endtask

   task automatic async_reset_check();
      #5;
      rst = 1'b1;
      #1;
      check_bits("rst_fly", 32'(fly_spawn), 32'd0);
      check_bits("rst_mosquito", 32'(mosquito_spawn), 32'd0);
      check_bits("rst_done", 32'(spawn_done), 32'd0);
      check_bits("rst_wave", 32'(wave_count), 32'd0);
      check_bits("rst_spider", 32'(spider_spawn), 32'd0);
      model_reset();
      @(posedge clk25);
      @(negedge clk25);
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0]  st;
      int unsigned len;
      cyc            = 0;
      rst            = 1'b1;
      stage_state    = 2'b00;
      fly_alive      = '0;
      mosquito_alive = '0;
      spider_alive   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk25);
      @(negedge clk25);
      check_bits("reset_fly", 32'(fly_spawn), 32'd0);
      check_bits("reset_mosquito", 32'(mosquito_spawn), 32'd0);
      check_bits("reset_done", 32'(spawn_done), 32'd0);
      check_bits("reset_wave", 32'(wave_count), 32'd0);
      rst = 1'b0;

      // Full normal sequence
      repeat (2) tick(2'b00);
      repeat (32) tick(2'b01);
      check_bits("full_seq_wave", 32'(wave_count), 32'd1);
      check_bits("full_seq_done", 32'(spawn_done), 32'd1);

      // Boss entry straight from NORMAL
      tick(2'b10);
      repeat (8) tick(2'b10);

      // Abort mid-sequence by going to CLEAR at cycle 12
      tick(2'b00);
      repeat (12) tick(2'b01);
      repeat (30) tick(2'b11);
      check_bits("abort_done", 32'(spawn_done), 32'd0);

      // Async reset during WAIT, stage held NORMAL afterwards
      tick(2'b00);
      repeat (7) tick(2'b01);
      async_reset_check();
      repeat (30) tick(2'b01);
      check_bits("post_reset_wave", 32'(wave_count), 32'd0);
      tick(2'b00);
      repeat (30) tick(2'b01);

      // Randomised stage sequences
      repeat (40) begin
         st  = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 40);
         repeat (len) tick(st);
      end

      // Wave counter saturation
      repeat (256) begin
         tick(2'b00);
         tick(2'b01);
      end
      tick(2'b00);
      check_bits("wave_saturated", 32'(wave_count), 32'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/enemy_spawn_scheduler.md
Name: enemy_spawn_scheduler

Overview:
Sequences enemy spawning for each stage cycle, driven by the 2-bit stage_state from the stage controller. On entry to the normal stage it issues staggered one-hot spawn pulses: flies first, then mosquitoes, one slot per interval. On entry to the boss stage it issues a same-cycle spider spawn pulse, so the spider is alive before the stage controller's one-tick-delayed check. It sits between the stage controller and the per-enemy sprite/state modules.

Parameters:
FLY_COUNT, 4, number of fly slots
MOSQUITO_COUNT, 12, number of mosquito slots
SPAWN_INTERVAL, 12_500_000, clk25 cycles between consecutive spawns (0.5 s); legal range 2 .. 2^INTERVAL_W-1
INTERVAL_W, 24, interval counter width

Ports:
clk25  input  1  system clock, 25 MHz
rst  input  1  asynchronous, active-high reset
stage_state  input  2  00 INIT, 01 NORMAL, 10 BOSS, 11 CLEAR
fly_alive  input  FLY_COUNT  per-fly alive flags
mosquito_alive  input  MOSQUITO_COUNT  per-mosquito alive flags
spider_alive  input  1  boss alive flag; monitored only, not used for sequencing
fly_spawn  output  FLY_COUNT  one-hot, one-cycle spawn pulse, registered
mosquito_spawn  output  MOSQUITO_COUNT  one-hot, one-cycle spawn pulse, registered
spider_spawn  output  1  one-cycle spawn pulse, combinational (Mealy)
spawn_done  output  1  high once all normal-stage slots have been processed
wave_count  output  8  count of entries into NORMAL, saturating at 255

Behaviour:
- Reset:
  - Clears fly_spawn, mosquito_spawn, spawn_done and wave_count to 0.
  - Sets FSM to IDLE and slot index to 0.
  - Sets prev_stage register to 2'b00, so spider_spawn=0.
  - Reset asserted mid-sequence aborts the sequence immediately; no further pulses.
- Edge detection:
  - prev_stage register samples stage_state every cycle.
  - enter_normal = (stage_state==01) && (prev_stage!=01).
  - enter_boss = (stage_state==10) && (prev_stage!=10).
- spider_spawn = enter_boss, combinational.
  - Asserted in the same cycle stage_state first reads BOSS, exactly one cycle per boss entry.
- FSM states: IDLE, WAIT, SPAWN, DONE.
- IDLE:
  - On enter_normal: go to WAIT, index<=0, counter<=0, wave_count<=wave_count+1 (saturating).
- WAIT:
  - Counter increments each cycle.
  - At counter==SPAWN_INTERVAL-1: go to SPAWN, counter<=0.
  - First pulse therefore appears SPAWN_INTERVAL+1 cycles after the enter_normal cycle.
- SPAWN (one cycle):
  - Index 0..FLY_COUNT-1 drives fly_spawn[index].
  - Index FLY_COUNT..FLY_COUNT+MOSQUITO_COUNT-1 drives mosquito_spawn[index-FLY_COUNT].
  - Pulse is registered: visible the cycle after SPAWN is entered, high for exactly 1 cycle.
  - If index is the last slot, go to DONE; otherwise index++ and return to WAIT.
- DONE:
  - spawn_done=1 while stage_state==01.
  - Leaving NORMAL goes to IDLE and clears spawn_done.
- Abort:
  - In WAIT or SPAWN, any stage_state!=01 forces IDLE next cycle.
  - Any pending pulse is suppressed; spawn_done stays 0.
- Index width: $clog2(FLY_COUNT+MOSQUITO_COUNT), no wrap; sequence ends at DONE.
- Re-entering NORMAL via INIT (next round) restarts from index 0.
- At most one spawn bit across fly_spawn/mosquito_spawn is high in any cycle.

Optional Feature:
SPAWN_SKIP_ALIVE_EN
- Defined: a slot whose alive bit is already 1 in the SPAWN cycle produces no pulse. The interval for that slot is not consumed: the FSM proceeds to the next slot's SPAWN on the next cycle. DONE is still reached after the last slot.
- Undefined: every slot is pulsed regardless of its alive flag.

Decomposition:
- Shared package stage_pkg holds:
  - STAGE_INIT/NORMAL/BOSS/CLEAR 2-bit constants
  - scheduler FSM state encoding
  - default FLY_COUNT/MOSQUITO_COUNT
- One sub-module, spawn_interval_timer:
  - Parameters INTERVAL and W.
  - Inputs: start, clear.
  - Output: one-cycle expire pulse.

Test Plan (FLY_COUNT=2, MOSQUITO_COUNT=3, SPAWN_INTERVAL=4):
- rst high; stage_state 00->01 at cycle 0 -> fly_spawn=01 at cycle 5, fly_spawn=10 at cycle 10, then mosquito_spawn 001/010/100 at cycles 15/20/25; spawn_done=1 from cycle 26; wave_count=1.
- stage_state 01->10 -> spider_spawn=1 in that same cycle only; no fly/mosquito pulses.
- stage_state 01->11 at cycle 12 (mid-sequence) -> no pulses after cycle 12; spawn_done stays 0; FSM in IDLE.
- rst asserted at cycle 7 during WAIT -> all outputs 0 asynchronously; after release with stage held at 01, no pulses until a fresh INIT->NORMAL entry.
- 256 INIT->NORMAL entries -> wave_count saturates at 255.
- With SPAWN_SKIP_ALIVE_EN defined and fly_alive=01 -> fly_spawn[0] never pulses; fly_spawn=10 at cycle 6; mosquito_spawn=001 at cycle 11.
